// File: rtl/program_loader8.sv
// Byte-stream program loader: parses SYNC/ADDR/LEN/DATA[/CSUM] frames into an
// internal program memory with a registered CPU fetch port. Define
// PROGRAM_LOADER_CHECKSUM_EN to require and verify the trailing CSUM byte.
module program_loader8 #(
  parameter int unsigned MAX_WORD_COUNT = 256,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] address,
  output logic [7:0] out,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       lock,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] frame_count
);

  localparam int unsigned AW = (MAX_WORD_COUNT > 1) ? $clog2(MAX_WORD_COUNT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_DATA,
    S_CSUM
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] ptr_q, ptr_d;
  logic [7:0] sum_q, sum_d;
  logic [8:0] remaining_q, remaining_d;
  logic [7:0] frame_count_q, frame_count_d;
  logic       done_q, done_d;
  logic       error_q, error_d;
  logic [7:0] out_q, out_d;
  logic       accept;
  logic       mem_we;

  // Contents survive rst; only the power-on image is zero.
  logic [7:0] mem_q [MAX_WORD_COUNT] = '{default: '0};

  assign accept = in_valid && !rst && !lock;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      sum_q         <= '0;
      remaining_q   <= '0;
      frame_count_q <= '0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      out_q         <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      sum_q         <= sum_d;
      remaining_q   <= remaining_d;
      frame_count_q <= frame_count_d;
      done_q        <= done_d;
      error_q       <= error_d;
      out_q         <= out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[ptr_q[AW-1:0]] <= in_data;
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    sum_d         = sum_q;
    remaining_d   = remaining_q;
    frame_count_d = frame_count_q;
    done_d        = 1'b0;
    error_d       = 1'b0;
    mem_we        = 1'b0;
    if (accept) begin
      unique case (state_q)
        S_IDLE: begin
          if (in_data == SYNC_BYTE) state_d = S_ADDR;
        end
        S_ADDR: begin
          ptr_d   = in_data;
          sum_d   = in_data;
          state_d = S_LEN;
        end
        S_LEN: begin
          remaining_d = (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
          sum_d       = sum_q + in_data;
          state_d     = S_DATA;
        end
        S_DATA: begin
          mem_we      = ({1'b0, ptr_q} < 9'(MAX_WORD_COUNT));
          ptr_d       = ptr_q + 8'd1;
          sum_d       = sum_q + in_data;
          remaining_d = remaining_q - 9'd1;
          if (remaining_q == 9'd1) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d       = S_IDLE;
            done_d        = 1'b1;
            frame_count_d = frame_count_q + 8'd1;
`endif
          end
        end
        S_CSUM: begin
          if (8'(sum_q + in_data) == 8'h00) begin
            done_d        = 1'b1;
            frame_count_d = frame_count_q + 8'd1;
          end else begin
            error_d = 1'b1;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Read-before-write falls out of sampling mem_q before the write edge lands.
  always_comb begin
    out_d = '0;
    if (!rst && ({1'b0, address} < 9'(MAX_WORD_COUNT))) begin
      out_d = mem_q[address[AW-1:0]];
    end
  end

  always_comb begin
    in_ready    = !rst && !lock;
    busy        = (state_q != S_IDLE);
    done        = done_q;
    error       = error_q;
    frame_count = frame_count_q;
    out         = out_q;
  end

endmodule
